// File: rtl/ryu_motion_controller.sv
// Ryu sprite motion controller: walk, punch and jump driven by a HID keycode.
// All motion advances once per video frame on the vs falling edge.
module ryu_motion_controller #(
  parameter int RESET_X      = 100,
  parameter int X_MAX        = 457,
  parameter int Y_GROUND     = 301,
  parameter int WALK_STEP    = 2,
  parameter int JUMP_V       = 12,
  parameter int PUNCH_FRAMES = 12
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  output logic [9:0] RyuX,
  output logic [9:0] RyuY,
  output logic       punch_active,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WALK  = 2'd1,
    S_PUNCH = 2'd2,
    S_JUMP  = 2'd3
  } state_t;

  localparam logic [7:0] K_A = 8'h04;
  localparam logic [7:0] K_D = 8'h07;
  localparam logic [7:0] K_W = 8'h1A;
  localparam logic [7:0] K_J = 8'h0D;

  localparam logic signed [10:0] L_STEP = 11'(WALK_STEP);
  localparam logic signed [10:0] L_XMAX = 11'(X_MAX);
  localparam logic signed [10:0] L_YG   = 11'(Y_GROUND);
  localparam logic [9:0]         L_X0   = 10'(RESET_X);
  localparam logic [7:0]         L_CNT0 = 8'(PUNCH_FRAMES - 1);
  localparam logic signed [5:0]  L_VY0  = 6'(-JUMP_V);

  logic                r_vs;
  state_t              r_state, w_nstate;
  logic [9:0]          r_x, w_nx;
  logic [9:0]          r_y, w_ny;
  logic [7:0]          r_cnt, w_ncnt;
  logic signed [5:0]   r_vy, w_nvy;
  logic signed [1:0]   r_dir, w_ndir;
  logic signed [1:0]   r_wdir, w_nwdir;
  logic                r_armed, w_narmed;
  logic                r_punch;
  logic                w_tick;
  logic                w_ka, w_kd, w_kw, w_kj;
  logic signed [10:0]  w_xs, w_ys, w_vyx, w_dx, w_yn;

  function automatic logic [9:0] f_clamp(input logic signed [10:0] v);
    if (v[10])
      return 10'd0;
    else if (v > L_XMAX)
      return L_XMAX[9:0];
    else
      return v[9:0];
  endfunction

  assign w_tick = r_vs & ~vs;
  assign w_ka   = (keycode == K_A);
  assign w_kd   = (keycode == K_D);
  assign w_kw   = (keycode == K_W);
  assign w_kj   = (keycode == K_J);
  assign w_xs   = signed'({1'b0, r_x});
  assign w_ys   = signed'({1'b0, r_y});
  assign w_vyx  = signed'({{5{r_vy[5]}}, r_vy});
  assign w_yn   = w_ys + w_vyx;

  // horizontal jump drift from the captured direction
  always_comb begin
    w_dx = 11'sd0;
    case (r_dir)
      2'sb11:  w_dx = -L_STEP;
      2'sb01:  w_dx = L_STEP;
      default: w_dx = 11'sd0;
    endcase
  end

  // vs edge detector producing the per-frame tick
  always_ff @(posedge vga_clk) begin
    if (Reset) r_vs <= 1'b1;
    else       r_vs <= vs;
  end

  // FSM state register
  always_ff @(posedge vga_clk) begin
    if (Reset)       r_state <= S_IDLE;
    else if (w_tick) r_state <= w_nstate;
  end

  // next state and next motion values for the coming frame tick
  always_comb begin
    w_nstate = r_state;
    w_nx     = r_x;
    w_ny     = r_y;
    w_ncnt   = r_cnt;
    w_nvy    = r_vy;
    w_ndir   = r_dir;
    w_nwdir  = r_wdir;
    w_narmed = r_armed | ~w_kj;
    case (r_state)
      S_IDLE, S_WALK: begin
        unique case (1'b1)
          (w_kj && r_armed): begin
            w_nstate = S_PUNCH;
            w_ncnt   = L_CNT0;
            w_narmed = 1'b0;
          end
          w_kw: begin
            w_nstate = S_JUMP;
            w_nvy    = L_VY0;
            w_ndir   = (r_state == S_WALK) ? r_wdir : 2'sb00;
          end
          w_ka: begin
            w_nstate = S_WALK;
            w_nx     = f_clamp(w_xs - L_STEP);
            w_nwdir  = 2'sb11;
          end
          w_kd: begin
            w_nstate = S_WALK;
            w_nx     = f_clamp(w_xs + L_STEP);
            w_nwdir  = 2'sb01;
          end
          default: w_nstate = S_IDLE;
        endcase
      end
      S_PUNCH: begin
        if (r_cnt == 8'd0) w_nstate = S_IDLE;
        else               w_ncnt   = r_cnt - 8'd1;
      end
      S_JUMP: begin
        w_nx = f_clamp(w_xs + w_dx);
        if (w_yn >= L_YG) begin
          w_ny     = L_YG[9:0];
          w_nstate = S_IDLE;
          w_nvy    = 6'sd0;
          w_ndir   = 2'sb00;
        end else begin
          w_ny  = w_yn[9:0];
          w_nvy = r_vy + 6'sd1;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // motion datapath registers, advanced only on frame ticks
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      r_x     <= L_X0;
      r_y     <= L_YG[9:0];
      r_cnt   <= 8'd0;
      r_vy    <= 6'sd0;
      r_dir   <= 2'sb00;
      r_wdir  <= 2'sb00;
      r_armed <= 1'b1;
      r_punch <= 1'b0;
    end else if (w_tick) begin
      r_x     <= w_nx;
      r_y     <= w_ny;
      r_cnt   <= w_ncnt;
      r_vy    <= w_nvy;
      r_dir   <= w_ndir;
      r_wdir  <= w_nwdir;
      r_armed <= w_narmed;
      r_punch <= (w_nstate == S_PUNCH);
    end
  end

  assign RyuX         = r_x;
  assign RyuY         = r_y;
  assign punch_active = r_punch;
  assign state        = r_state;

endmodule

// File: doc/ryu_motion_controller.md
RYU_MOTION_CONTROLLER -- requirements
Module: ryu_motion_controller

Interface
REQ-001 Parameter: RESET_X, default 100, sprite left edge after reset.
REQ-002 Parameter: X_MAX, default 457 (640-183), largest legal RyuX.
REQ-003 Parameter: Y_GROUND, default 301 (480-179), RyuY when standing.
REQ-004 Parameter: WALK_STEP, default 2, pixels moved per frame while walking or jumping.
REQ-005 Parameter: JUMP_V, default 12, initial upward speed in pixels/frame.
REQ-006 Parameter: PUNCH_FRAMES, default 12, frames the punch pose is held.
REQ-007 Port: vga_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 Port: Reset, input, 1, synchronous, active-high.
REQ-009 Port: vs, input, 1, VGA vertical sync, active-low.
REQ-010 Port: keycode, input, 8, current USB HID keycode; 0x04 A = left, 0x07 D = right, 0x1A W = jump, 0x0D J = punch, anything else = none.
REQ-011 Port: RyuX, output, 10, registered sprite left edge fed to the sprite stages.
REQ-012 Port: RyuY, output, 10, registered sprite top edge.
REQ-013 Port: punch_active, output, 1, high selects the punch sprite over the idle/walk sprite.
REQ-014 Port: state, output, 2, current FSM state: 0 IDLE, 1 WALK, 2 PUNCH, 3 JUMP.

Function
REQ-015 The block SHALL register vs and generate frame_tick, a one-cycle pulse on the cycle after each detected 1->0 transition of vs.
REQ-016 All position, state and counter updates SHALL occur only on the frame_tick cycle; outputs SHALL hold their values on all other cycles.
REQ-017 IDLE: keycode J with punch_armed=1 -> PUNCH; W -> JUMP; A or D -> WALK; otherwise stay in IDLE.
REQ-018 WALK: RyuX moves by -WALK_STEP (A) or +WALK_STEP (D) each tick; J, W, and none keycodes are evaluated with the same priority as in IDLE.
REQ-019 WALK: any keycode other than A/D/J/W SHALL return the FSM to IDLE on that tick with no movement.
REQ-020 PUNCH: entry loads punch_cnt=PUNCH_FRAMES-1 and clears punch_armed; punch_active=1 during the state.
REQ-021 PUNCH: punch_cnt decrements each tick, keycode is ignored, and no movement occurs; the tick on which punch_cnt=0 -> IDLE, with punch_active=0 on the next cycle.
REQ-022 punch_armed SHALL be set on any tick where keycode != 0x0D, so a held J gives exactly one punch.
REQ-023 JUMP: entry captures dir (-1 for A/last-left walk, +1 for right, 0 from IDLE) and loads signed 6-bit vy=-JUMP_V.
REQ-024 JUMP: each tick RyuY += vy, vy += 1, RyuX += dir*WALK_STEP; keycode is ignored.
REQ-025 JUMP: when the computed RyuY >= Y_GROUND, RyuY SHALL be set to Y_GROUND and the FSM SHALL go to IDLE on the same tick.
REQ-026 All X/Y arithmetic SHALL use signed 11-bit intermediates; RyuX SHALL clamp to [0, X_MAX] and never wrap (e.g. X=1 with a -2 step gives 0).
REQ-027 punch_active SHALL be registered and SHALL equal 1 exactly when state=PUNCH.

Reset
REQ-028 While Reset=1 on a rising edge: RyuX=RESET_X, RyuY=Y_GROUND, state=IDLE, punch_active=0, punch_cnt=0, vy=0, dir=0, punch_armed=1, vs register=1.
REQ-029 A reset asserted mid-PUNCH or mid-JUMP SHALL take effect on that same edge, overriding any coincident frame_tick.

Verification
REQ-030 Reset then hold D for 10 frames -> RyuX=120, RyuY=301, state=1; releasing D (keycode 0) on the next tick -> state=0, RyuX stays 120.
REQ-031 From RyuX=1 hold A for 3 frames -> RyuX 0, 0, 0 with no wrap to large values; from RyuX=456 hold D -> RyuX=457 and holds there.
REQ-032 Hold J for 30 frames from IDLE -> punch_active=1 for exactly 12 frames, then 0 with no second punch; release J for 1 frame, then press J -> new 12-frame punch.
REQ-033 Press W from IDLE -> RyuY sequence 289, 278, 268, ..., returning to exactly 301 with state=0 after 25 ticks; RyuX unchanged.
REQ-034 Walk right, then press W -> RyuX rises by 2 per tick through the jump; press A mid-jump -> no effect on RyuX until landing.
REQ-035 Assert Reset during tick 5 of PUNCH -> next cycle shows punch_active=0, state=0, RyuX=100, RyuY=301; vs held high (no falling edge) -> no output change over 1000 cycles.
